// File: rtl/int_divider.sv
// Iterative restoring divider for UDIV/SDIV. One quotient bit per cycle.
// Results are registered on entry to FINISH and held until the next result.
module int_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude, shifts out left as quotient shifts in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic             qneg_q, rneg_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;

  logic             accept, dvs_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] prem_nxt, quo_nxt;

  assign accept   = start && (state_q != DIVIDE);
  assign dvs_zero = (divisor == '0);
  assign a_neg    = is_signed & dividend[WIDTH-1];
  assign b_neg    = is_signed & divisor[WIDTH-1];
  // MIN negates to itself, which reads correctly as unsigned 2^(WIDTH-1)
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor  : divisor;

  // Full WIDTH+1-bit trial so an unsigned partial remainder never loses its MSB
  assign trial    = {prem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign ge       = ~trial[WIDTH];
  assign prem_nxt = ge ? trial[WIDTH-1:0] : {prem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_nxt  = {dvd_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FINISH: begin
        if (accept) state_d = dvs_zero ? FINISH : DIVIDE;
        else        state_d = IDLE;
      end
      DIVIDE:  if (cnt_q == '0) state_d = FINISH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == DIVIDE);
    done = (state_q == FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dvd_q  <= a_mag;
      dvs_q  <= b_mag;
      prem_q <= '0;
      cnt_q  <= CW'(WIDTH-1);
      if (dvs_zero) begin
        quot_q <= '0;
        rem_q  <= dividend;
        dbz_q  <= 1'b1;
      end
    end else if (state_q == DIVIDE) begin
      prem_q <= prem_nxt;
      dvd_q  <= quo_nxt;
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        quot_q <= qneg_q ? -quo_nxt  : quo_nxt;
        rem_q  <= rneg_q ? -prem_nxt : prem_nxt;
        dbz_q  <= 1'b0;
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_int_divider.sv
// Directed-vector bench for int_divider: arithmetic corners, handshake and reset abort.
module tb_int_divider;
  localparam int W = 64;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int           n_chk = 0, n_pass = 0;

  int_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = cycle index (1 = cycle after accept edge) in which done is seen; 0 on timeout
  task automatic wait_done(output int lat, output int bcnt, output int ovl);
    lat = 0; bcnt = 0; ovl = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && done) ovl++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz, input int elat);
    int lat, bcnt, ovl;
    drive(s, a, b);
    wait_done(lat, bcnt, ovl);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy cycles"}, 64'(bcnt), 64'(elat - 1));
    chk({tag, " busy&done"}, 64'(ovl), 64'd0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
    @(negedge clk);
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, ovl, nd;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst quotient", quotient, 64'd0);
    chk("rst remainder", remainder, 64'd0);
    chk("rst dbz", 64'(div_by_zero), 64'd0);
    reset_n = 1'b1;

    run("u 100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);
    run("s -7/2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
    run("s 7/-2", 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
        64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65);
    run("s -7/-2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
        64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
    run("u x/0", 1'b0, 64'h1234, 64'd0, 64'd0, 64'h1234, 1'b1, 1);
    run("s -5/0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1);
    run("s MIN/-1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 64'd0, 1'b0, 65);
    run("s MIN/2", 1'b1, 64'h8000_0000_0000_0000, 64'd2,
        64'hC000_0000_0000_0000, 64'd0, 1'b0, 65);
    run("u max/1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65);
    run("u max/2^63", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
        64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65);

    // start during DIVIDE is dropped
    drive(1'b0, 64'd1000, 64'd10);
    repeat (10) @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 64'd5; divisor = 64'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt, ovl);
    chk("ignore latency", 64'(lat), 64'd55);
    chk("ignore quotient", quotient, 64'd100);
    chk("ignore remainder", remainder, 64'd0);
    count_dones(80, nd);
    chk("ignore extra done", 64'(nd), 64'd0);
    chk("ignore held quotient", quotient, 64'd100);

    // back-to-back accept on the FINISH edge
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    wait_done(lat, bcnt, ovl);
    chk("b2b first latency", 64'(lat), 64'd65);
    chk("b2b first quotient", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
    chk("b2b first remainder", remainder, 64'hFFFF_FFFF_FFFF_FFFE);
    start = 1'b1; is_signed = 1'b0; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt, ovl);
    chk("b2b second latency", 64'(lat), 64'd65);
    chk("b2b second busy", 64'(bcnt), 64'd64);
    chk("b2b second quotient", quotient, 64'd333);
    chk("b2b second remainder", remainder, 64'd1);

    // asynchronous reset mid-division
    drive(1'b0, 64'd100, 64'd7);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort quotient", quotient, 64'd0);
    chk("abort remainder", remainder, 64'd0);
    chk("abort dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_dones(80, nd);
    chk("abort no done", 64'(nd), 64'd0);
    run("post-abort 100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
